// File: rtl/spi_target.sv
// SPI mode-0 target with synchronized inputs, a one-byte transmit holding
// register and a one-byte receive output.
module spi_target #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_cs_n,
   input  logic       spi_sclk,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_underrun
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic                   cs_prev_q, cs_prev_d;
   logic                   sclk_prev_q, sclk_prev_d;

   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic       byte_done_q, byte_done_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic [7:0] hold_q, hold_d;
   logic       hold_full_q, hold_full_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       underrun_q, underrun_d;

   logic cs_s, sclk_s, mosi_s;
   logic cs_fall, sclk_rise, sclk_fall;
   logic load;

   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_fall   = cs_prev_q & ~cs_s;
   assign sclk_rise = ~sclk_prev_q & sclk_s;
   assign sclk_fall = sclk_prev_q & ~sclk_s;

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_ready    = ~hold_full_q;
   assign tx_underrun = underrun_q;

   // Input synchronizer chains and previous-value copies for edge detection
   always_comb begin
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      cs_prev_d   = cs_s;
      sclk_prev_d = sclk_s;
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // FSM next-state: enter on cs_n falling edge, leave whenever cs_n is high
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (cs_fall) state_d = ACTIVE;
         ACTIVE:  if (cs_s)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: MISO is driven only while selected
   always_comb begin
      spi_miso    = 1'b0;
      spi_miso_oe = 1'b0;
      if (state_q == ACTIVE) begin
         spi_miso    = tx_shift_q[7];
         spi_miso_oe = 1'b1;
      end
   end

   // Shift datapath, byte loading and holding-register capture
   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      byte_done_d = byte_done_q;
      rx_shift_d  = rx_shift_q;
      tx_shift_d  = tx_shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      load        = 1'b0;

      if (state_q == IDLE) begin
         if (cs_fall) begin
            load        = 1'b1;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
         end
      end else if (cs_s) begin
         // deselect: drop any partial byte, keep the holding register
         bit_cnt_d   = 3'd0;
         byte_done_d = 1'b0;
         rx_shift_d  = '0;
      end else begin
         if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
               rx_data_d   = {rx_shift_q[6:0], mosi_s};
               rx_valid_d  = 1'b1;
               byte_done_d = 1'b1;
            end
         end
         if (sclk_fall) begin
            if (byte_done_q) begin
               load        = 1'b1;
               byte_done_d = 1'b0;
            end else begin
               tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
         end
      end

      // load sees the pre-capture holding state; a same-cycle capture stays queued
      if (load) begin
         if (hold_full_q) begin
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
         end else begin
            tx_shift_d = IDLE_BYTE;
            underrun_d = 1'b1;
         end
      end
      if (tx_valid && !hold_full_q) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end
   end

   // Datapath and synchronizer registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cs_sync_q   <= '1;
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         bit_cnt_q   <= '0;
         byte_done_q <= 1'b0;
         rx_shift_q  <= '0;
         tx_shift_q  <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         cs_sync_q   <= cs_sync_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         cs_prev_q   <= cs_prev_d;
         sclk_prev_q <= sclk_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_done_q <= byte_done_d;
         rx_shift_q  <= rx_shift_d;
         tx_shift_q  <= tx_shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
      end
   end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI mode-0 initiator model plus
// per-scenario tasks with hand-computed expectations.
module tb_spi_target;

   localparam int HALF = 6;   // SCLK half period in clk cycles
   localparam int SYNC = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       spi_cs_n = 1'b1;
   logic       spi_sclk = 1'b0;
   logic       spi_mosi = 1'b0;
   logic       spi_miso;
   logic       spi_miso_oe;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       tx_underrun;

   int errors = 0;
   int checks = 0;

   // monitor counters (written only by the monitor)
   int         rx_cnt = 0;
   int         ur_cnt = 0;
   logic [7:0] rx_log [4];
   int         ur_snap = 0;

   spi_target #(.SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
      .clk(clk), .reset(reset),
      .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_underrun(tx_underrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rx_valid) begin
         rx_log[rx_cnt % 4] <= rx_data;
         rx_cnt <= rx_cnt + 1;
      end
      if (tx_underrun) ur_cnt <= ur_cnt + 1;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic queue_tx(input logic [7:0] v);
      tx_data  = v;
      tx_valid = 1'b1;
      wait_clks(1);
      tx_valid = 1'b0;
   endtask

   task automatic cs_start();
      spi_cs_n = 1'b0;
      wait_clks(HALF);
   endtask

   task automatic cs_end();
      wait_clks(HALF);
      spi_cs_n = 1'b1;
      wait_clks(HALF);
   endtask

   // One mode-0 byte; ur_snap is taken after the last rising edge, before the
   // trailing falling edge that starts loading a following byte.
   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      for (int i = 7; i >= 0; i--) begin
         spi_mosi = tx[i];
         wait_clks(HALF);
         rx[i] = spi_miso;
         spi_sclk = 1'b1;
         wait_clks(HALF);
         if (i == 0) ur_snap = ur_cnt;
         spi_sclk = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      wait_clks(3);
      checks++; if (spi_miso !== 1'b0)    begin errors++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", spi_miso_oe); end
      checks++; if (rx_data !== 8'h00)    begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
      checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
      checks++; if (tx_ready !== 1'b1)    begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
      checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun); end
      reset = 1'b0;
      wait_clks(4);
   endtask

   task automatic test_basic();
      logic [7:0] m;
      int rx_base, ur_base;
      queue_tx(8'hA5);
      checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_full got=%b exp=0", tx_ready); end
      queue_tx(8'h77);   // must be ignored, holding register is full
      rx_base = rx_cnt; ur_base = ur_cnt;
      cs_start();
      checks++; if (tx_ready !== 1'b1)    begin errors++; $display("FAIL basic_ready_after_cs got=%b exp=1", tx_ready); end
      checks++; if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL basic_oe got=%b exp=1", spi_miso_oe); end
      spi_byte(8'h3C, m);
      checks++; if (m !== 8'hA5)                  begin errors++; $display("FAIL basic_miso got=%h exp=a5", m); end
      checks++; if (rx_cnt - rx_base !== 1)       begin errors++; $display("FAIL basic_rx_pulses got=%0d exp=1", rx_cnt - rx_base); end
      checks++; if (rx_log[(rx_cnt-1)%4] !== 8'h3C) begin errors++; $display("FAIL basic_rx_log got=%h exp=3c", rx_log[(rx_cnt-1)%4]); end
      checks++; if (ur_snap - ur_base !== 0)      begin errors++; $display("FAIL basic_underrun got=%0d exp=0", ur_snap - ur_base); end
      cs_end();
      checks++; if (rx_data !== 8'h3C)    begin errors++; $display("FAIL basic_rx_data got=%h exp=3c", rx_data); end
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_idle got=%b exp=0", spi_miso_oe); end
   endtask

   task automatic test_underrun();
      logic [7:0] m;
      int ur_base;
      ur_base = ur_cnt;
      cs_start();
      spi_byte(8'h00, m);
      checks++; if (m !== 8'hFF)             begin errors++; $display("FAIL underrun_miso got=%h exp=ff", m); end
      checks++; if (ur_snap - ur_base !== 1) begin errors++; $display("FAIL underrun_pulses got=%0d exp=1", ur_snap - ur_base); end
      cs_end();
      checks++; if (rx_data !== 8'h00)       begin errors++; $display("FAIL underrun_rx_data got=%h exp=00", rx_data); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] m1, m2;
      int rx_base, ur_base;
      queue_tx(8'h11);
      rx_base = rx_cnt; ur_base = ur_cnt;
      cs_start();
      fork
         begin
            spi_byte(8'h01, m1);
            spi_byte(8'h02, m2);
         end
         begin
            wait_clks(20);
            queue_tx(8'h22);
         end
      join
      checks++; if (m1 !== 8'h11) begin errors++; $display("FAIL b2b_miso1 got=%h exp=11", m1); end
      checks++; if (m2 !== 8'h22) begin errors++; $display("FAIL b2b_miso2 got=%h exp=22", m2); end
      checks++; if (rx_cnt - rx_base !== 2) begin errors++; $display("FAIL b2b_rx_pulses got=%0d exp=2", rx_cnt - rx_base); end
      checks++; if (rx_log[rx_base%4] !== 8'h01)     begin errors++; $display("FAIL b2b_rx1 got=%h exp=01", rx_log[rx_base%4]); end
      checks++; if (rx_log[(rx_base+1)%4] !== 8'h02) begin errors++; $display("FAIL b2b_rx2 got=%h exp=02", rx_log[(rx_base+1)%4]); end
      checks++; if (ur_snap - ur_base !== 0) begin errors++; $display("FAIL b2b_underrun got=%0d exp=0", ur_snap - ur_base); end
      cs_end();
   endtask

   task automatic test_abort();
      logic [7:0] m;
      int rx_base;
      rx_base = rx_cnt;
      cs_start();
      for (int k = 0; k < 2; k++) begin
         spi_sclk = 1'b1; wait_clks(HALF);
         spi_sclk = 1'b0; wait_clks(HALF);
      end
      spi_sclk = 1'b1; wait_clks(HALF);
      checks++; if (spi_miso_oe !== 1'b1) begin errors++; $display("FAIL abort_oe_before got=%b exp=1", spi_miso_oe); end
      spi_cs_n = 1'b1;
      wait_clks(SYNC + 1);
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_oe_after got=%b exp=0", spi_miso_oe); end
      spi_sclk = 1'b0;
      wait_clks(HALF);
      checks++; if (rx_cnt - rx_base !== 0) begin errors++; $display("FAIL abort_rx_pulses got=%0d exp=0", rx_cnt - rx_base); end
      cs_start();
      spi_byte(8'h96, m);
      cs_end();
      checks++; if (rx_cnt - rx_base !== 1) begin errors++; $display("FAIL abort_next_pulses got=%0d exp=1", rx_cnt - rx_base); end
      checks++; if (rx_data !== 8'h96)      begin errors++; $display("FAIL abort_next_rx got=%h exp=96", rx_data); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] m;
      int rx_base;
      rx_base = rx_cnt;
      cs_start();
      queue_tx(8'hC3);   // holding register empty after cs load, now full
      for (int k = 0; k < 4; k++) begin
         spi_mosi = k[0];
         spi_sclk = 1'b1; wait_clks(HALF);
         spi_sclk = 1'b0; wait_clks(HALF);
      end
      reset = 1'b1;
      wait_clks(1);
      checks++; if (spi_miso !== 1'b0)    begin errors++; $display("FAIL rstmid_miso got=%b exp=0", spi_miso); end
      checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe got=%b exp=0", spi_miso_oe); end
      checks++; if (rx_data !== 8'h00)    begin errors++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
      checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL rstmid_rx_valid got=%b exp=0", rx_valid); end
      checks++; if (tx_ready !== 1'b1)    begin errors++; $display("FAIL rstmid_tx_ready got=%b exp=1", tx_ready); end
      checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL rstmid_underrun got=%b exp=0", tx_underrun); end
      spi_cs_n = 1'b1;
      wait_clks(3);
      reset = 1'b0;
      wait_clks(10);
      checks++; if (rx_cnt - rx_base !== 0) begin errors++; $display("FAIL rstmid_rx_pulses got=%0d exp=0", rx_cnt - rx_base); end
      checks++; if (spi_miso_oe !== 1'b0)   begin errors++; $display("FAIL rstmid_oe_wait got=%b exp=0", spi_miso_oe); end
      cs_start();
      spi_byte(8'h5A, m);
      cs_end();
      checks++; if (rx_data !== 8'h5A)      begin errors++; $display("FAIL rstmid_next_rx got=%h exp=5a", rx_data); end
      checks++; if (rx_cnt - rx_base !== 1) begin errors++; $display("FAIL rstmid_next_pulses got=%0d exp=1", rx_cnt - rx_base); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underrun();
      test_back_to_back();
      test_abort();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flop stages on each SPI input; legal range 2-3.
REQ-002 Parameter IDLE_BYTE, default 8'hFF: byte shifted out when no transmit byte is queued.
REQ-003 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 spi_cs_n  input  1  chip select from the SPI initiator, active-low (board pin pin18_cs).
REQ-006 spi_sclk  input  1  SPI clock from the initiator, mode 0 (pin19_sclk).
REQ-007 spi_mosi  input  1  serial data from the initiator (pin4_mosi).
REQ-008 spi_miso  output  1  serial data to the initiator (pin20_miso).
REQ-009 spi_miso_oe  output  1  tristate enable for spi_miso; the top level drives the pin to 1'bz when this is 0.
REQ-010 rx_data  output  8  last fully received byte.
REQ-011 rx_valid  output  1  one-clk pulse: rx_data is updated.
REQ-012 tx_data  input  8  next byte to transmit.
REQ-013 tx_valid  input  1  tx_data is valid.
REQ-014 tx_ready  output  1  the transmit holding register is empty.
REQ-015 tx_underrun  output  1  one-clk pulse: IDLE_BYTE was loaded because the holding register was empty.

Function
REQ-016 spi_cs_n, spi_sclk and spi_mosi SHALL each pass through SYNC_STAGES flops; all logic uses the synchronized copies, and sclk edges are detected from the previous synchronized value.
REQ-017 Minimum supported SCLK high or low time SHALL be SYNC_STAGES+2 clk periods.
REQ-018 FSM states SHALL be IDLE and ACTIVE; IDLE->ACTIVE on synchronized cs_n falling edge; ACTIVE->IDLE on synchronized cs_n high.
REQ-019 On IDLE->ACTIVE, the shift-out register SHALL load the holding register if it is full (marking it empty), else IDLE_BYTE with a tx_underrun pulse; bit counter cleared to 0.
REQ-020 In ACTIVE, on each synchronized sclk rising edge: shift in mosi MSB-first and increment the 3-bit bit counter (wraps 7->0).
REQ-021 On the rising edge where the counter wraps 7->0, rx_data SHALL take the 8 assembled bits and rx_valid SHALL pulse high for exactly one clk in the following cycle.
REQ-022 On each synchronized sclk falling edge in ACTIVE: if a byte has just completed (counter==0 after a wrap), load the next byte per REQ-019 rules; otherwise shift the shift-out register left by one.
REQ-023 spi_miso SHALL equal bit 7 of the shift-out register while ACTIVE, and 0 in IDLE.
REQ-024 spi_miso_oe SHALL be 1 only in ACTIVE.
REQ-025 tx_ready SHALL be 1 when the holding register is empty; tx_valid&&tx_ready captures tx_data into the holding register on that clk edge.
REQ-026 If a load and a capture occur on the same cycle, the load SHALL use the prior holding content (IDLE_BYTE if empty), and the captured byte SHALL remain queued for the next load.
REQ-027 cs_n deasserting mid-byte SHALL discard the partial byte (no rx_valid), clear the counter, return to IDLE, and preserve the holding register.
REQ-028 tx_data SHALL be ignored while tx_ready=0; the queued byte is never overwritten.

Reset
REQ-029 While reset is high: state=IDLE; counter=0; holding register empty (tx_ready=1); shift registers=0; rx_data=8'h00; rx_valid=0; tx_underrun=0; spi_miso=0; spi_miso_oe=0; synchronizer flops set to cs_n=1, sclk=0, mosi=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer immediately with no rx_valid pulse; after release, the block waits for a fresh cs_n falling edge.

Verification
REQ-031 Queue tx 8'hA5; initiator sends 8'h3C in mode 0 -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with a single rx_valid pulse; tx_ready returns to 1 at the cs_n falling edge.
REQ-032 Nothing queued; transfer of 8'h00 -> miso=8'hFF; tx_underrun pulses once; rx_data=8'h00.
REQ-033 Queue 8'h11, then queue 8'h22 during byte 1; 2-byte burst 8'h01,8'h02 -> miso 8'h11,8'h22; two rx_valid pulses with 8'h01 then 8'h02; no underrun.
REQ-034 cs_n released after 5 sclk edges -> no rx_valid; spi_miso_oe=0 within SYNC_STAGES+1 clk; the next full byte is received correctly.
REQ-035 Reset asserted after 4 bits -> all outputs take their REQ-029 values; a later transfer of 8'h5A yields rx_data=8'h5A.
